// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch key debounce, run/pause/clear FSM and 1 Hz tick generator
module stopwatch_ctrl #(
  parameter int SEC_CNT = 50_000_000,
  parameter int DEB_CNT = 1_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic KEY_SS,
  input  logic KEY_CLR,
  output logic EN1HZ,
  output logic CLR,
  output logic RUN
);

  localparam int PW = (SEC_CNT > 1) ? $clog2(SEC_CNT) : 1;
  localparam int DW = $clog2(DEB_CNT + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SEC_CNT - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CNT - 1);

  // Key index 0 is start/stop, index 1 is clear.
  localparam int K_SS  = 0;
  localparam int K_CLR = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  logic [1:0]    rst_pipe;
  logic          rst_n;
  logic [1:0]    key_raw;
  logic [1:0]    sync_a;
  logic [1:0]    sync_b;
  logic [1:0]    acc;
  logic [1:0]    press;
  logic [DW-1:0] deb_cnt [2];
  state_t        state;
  state_t        state_next;
  logic          clr_fire;
  logic          counting;
  logic [PW-1:0] presc;

  assign key_raw = {KEY_CLR, KEY_SS};

  // Reset synchronizer: asserts immediately, releases only after two clean edges.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign rst_n = rst_pipe[1];

  // Two-flop synchronizers for the raw pushbuttons; released (1) out of reset.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 2'b11;
      sync_b <= 2'b11;
    end else begin
      sync_a <= key_raw;
      sync_b <= sync_a;
    end
  end

  // Per-key debounce: a level must differ from the accepted one for DEB_CNT
  // consecutive cycles before it is taken; a 1->0 acceptance emits one press pulse.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= 2'b11;
      press      <= 2'b00;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync_b[i] == acc[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_MAX) begin
          acc[i]     <= sync_b[i];
          deb_cnt[i] <= '0;
          press[i]   <= acc[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: SS wins while running, CLR wins when stopped.
  always_comb begin
    state_next = state;
    clr_fire   = 1'b0;
    case (state)
      S_IDLE, S_PAUSE: begin
        if (press[K_CLR]) begin
          state_next = S_IDLE;
          clr_fire   = 1'b1;
        end else if (press[K_SS]) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (press[K_SS]) begin
          state_next = S_PAUSE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Count only while staying in RUN, so a pause on the wrap cycle keeps the tick pending.
  assign counting = (state == S_RUN) && (state_next == S_RUN);

  // Prescaler: 0..SEC_CNT-1 while running, holds in pause, cleared with CLR.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (clr_fire) begin
      presc <= '0;
    end else if (counting) begin
      presc <= (presc == PRESC_MAX) ? '0 : presc + 1'b1;
    end
  end

  // Registered outputs: tick on wrap, clear pulse, run status.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      EN1HZ <= 1'b0;
      CLR   <= 1'b0;
      RUN   <= 1'b0;
    end else begin
      EN1HZ <= counting && (presc == PRESC_MAX);
      CLR   <= clr_fire;
      RUN   <= (state_next == S_RUN);
    end
  end

endmodule
